// File: rtl/sobel_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sobel_ctrl_pkg
// Shared types for the sobel frame sequencer.
//   ctrl_state_t : frame sequencer states (IDLE, RUN, DRAIN, DONE)
//   quota_w(n)   : bit width of a counter that must be able to hold the value n
// -----------------------------------------------------------------------------
package sobel_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ctrl_state_t;

   // A counter that saturates at n needs to represent 0..n inclusive.
   function automatic int unsigned quota_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl_if
// FIFO-style handshake bundle between the frame sequencer, the upstream pixel
// FIFO, the sobel stage and the downstream FIFO.
//   src_empty   : upstream FIFO empty
//   src_rd_en   : upstream FIFO read strobe (gated sobel read)
//   sobel_rd_en : sobel in_rd_en
//   sobel_empty : drives sobel in_empty
//   dst_full    : downstream FIFO full
//   sobel_wr_en : sobel out_wr_en (data goes straight to the downstream FIFO)
//   sobel_full  : drives sobel out_full
// modport master : the sequencer side; slave : the FIFO/sobel side.
// -----------------------------------------------------------------------------
interface sobel_frame_ctrl_if;

   logic src_empty;
   logic src_rd_en;
   logic sobel_rd_en;
   logic sobel_empty;
   logic dst_full;
   logic sobel_wr_en;
   logic sobel_full;

   modport master (
      input  src_empty,
      input  sobel_rd_en,
      input  dst_full,
      input  sobel_wr_en,
      output src_rd_en,
      output sobel_empty,
      output sobel_full
   );

   modport slave (
      output src_empty,
      output sobel_rd_en,
      output dst_full,
      output sobel_wr_en,
      input  src_rd_en,
      input  sobel_empty,
      input  sobel_full
   );

endinterface

// File: rtl/sobel_frame_ctrl_quota_counter.sv
// -----------------------------------------------------------------------------
// quota_counter
// Clearable up-counter that saturates at QUOTA.
//   clock    : clock
//   reset    : synchronous active-low reset
//   clear    : return count to 0 (takes priority over inc)
//   inc      : count one event (ignored once at QUOTA)
//   count    : current count, quota_w(QUOTA) bits
//   at_quota : count == QUOTA
// -----------------------------------------------------------------------------
module quota_counter
   import sobel_ctrl_pkg::*;
#(
   parameter  int unsigned QUOTA = 12,
   localparam int unsigned W     = quota_w(QUOTA)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         at_quota
);

   assign at_quota = (count == W'(QUOTA));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && !at_quota) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl
// Frame sequencer around the sobel streaming stage. It opens the sobel input
// gate for exactly IN_QUOTA pixels, keeps the output gate open until OUT_QUOTA
// writes have landed, and only then admits the next frame.
//   clock       : clock
//   reset       : synchronous active-low reset
//   start       : request one frame (pulse or level)
//   hs          : handshake bundle (master side), see sobel_frame_ctrl_if
//   busy        : frame in progress (RUN, DRAIN or DONE)
//   frame_done  : one-cycle pulse per completed frame
//   frame_count : completed frames, wraps
//   err         : sticky protocol error (read while empty / write while full)
// -----------------------------------------------------------------------------
module sobel_frame_ctrl
   import sobel_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH     = 568,
   parameter int unsigned HEIGHT    = 320,
   parameter int unsigned IN_QUOTA  = WIDTH * HEIGHT,
   parameter int unsigned OUT_QUOTA = WIDTH * HEIGHT
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   sobel_frame_ctrl_if.master        hs,
   output logic                      busy,
   output logic                      frame_done,
   output logic [15:0]               frame_count,
   output logic                      err
);

   localparam int unsigned IN_W  = quota_w(IN_QUOTA);
   localparam int unsigned OUT_W = quota_w(OUT_QUOTA);

   ctrl_state_t      state;
   ctrl_state_t      next_state;
   logic             pending;
   logic             enter_run;

   logic [IN_W-1:0]  in_cnt;
   logic [OUT_W-1:0] out_cnt;
   logic             in_at_quota;
   logic             out_at_quota;
   logic             in_inc;
   logic             out_inc;
   logic             in_reach;
   logic             out_reach;

   logic             gate_in;
   logic             gate_out;

   // Handshake gating: purely combinational so the gate closes in the same
   // cycle that the last quota read is accepted.
   assign gate_in         = (state == ST_RUN) && !in_at_quota;
   assign gate_out        = (state == ST_RUN) || (state == ST_DRAIN);
   assign hs.sobel_empty  = hs.src_empty | ~gate_in;
   assign hs.src_rd_en    = hs.sobel_rd_en & gate_in;
   assign hs.sobel_full   = hs.dst_full | ~gate_out;

   assign in_inc  = hs.src_rd_en;
   assign out_inc = hs.sobel_wr_en & gate_out & ~hs.dst_full;

   // "Reach" looks one event ahead so RUN->DRAIN and DRAIN->DONE are taken
   // the cycle right after the final read/write rather than one later.
   assign in_reach  = in_at_quota  | (in_inc  && (in_cnt  == IN_W'(IN_QUOTA - 1)));
   assign out_reach = out_at_quota | (out_inc && (out_cnt == OUT_W'(OUT_QUOTA - 1)));

   quota_counter #(.QUOTA(IN_QUOTA)) u_in_cnt (
      .clock    (clock),
      .reset    (reset),
      .clear    (enter_run),
      .inc      (in_inc),
      .count    (in_cnt),
      .at_quota (in_at_quota)
   );

   quota_counter #(.QUOTA(OUT_QUOTA)) u_out_cnt (
      .clock    (clock),
      .reset    (reset),
      .clear    (enter_run),
      .inc      (out_inc),
      .count    (out_cnt),
      .at_quota (out_at_quota)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:  if (start || pending) next_state = ST_RUN;
         // A write that saturates out_cnt during RUN is remembered by the
         // counter and picked up by out_at_quota on the first DRAIN cycle.
         ST_RUN:   if (in_reach)         next_state = ST_DRAIN;
         ST_DRAIN: if (out_reach)        next_state = ST_DONE;
         ST_DONE:  next_state = (start || pending) ? ST_RUN : ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
      enter_run = (next_state == ST_RUN) && (state != ST_RUN);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= ST_IDLE;
         pending     <= 1'b0;
         frame_count <= '0;
         err         <= 1'b0;
      end else begin
         state <= next_state;

         // Starts arriving mid-frame collapse into a single queued request.
         if (enter_run) begin
            pending <= 1'b0;
         end else if (start && gate_out) begin
            pending <= 1'b1;
         end

         if (state == ST_DONE) begin
            frame_count <= frame_count + 16'd1;
         end

         if ((hs.sobel_rd_en && !gate_in) || (hs.sobel_wr_en && hs.sobel_full)) begin
            err <= 1'b1;
         end
      end
   end

   assign busy       = (state != ST_IDLE);
   assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_frame_ctrl
// Directed bench for sobel_frame_ctrl with a 4x3 frame (quota 12). A tiny
// behavioural sobel reads whenever not empty and writes one output per pixel
// read whenever not full. Expected frame completions (cycle and pre-increment
// frame_count) are queued by the stimulus and checked by a separate monitor.
// -----------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

   localparam int unsigned W = 4;
   localparam int unsigned H = 3;
   localparam int unsigned Q = W * H;

   typedef struct {
      int unsigned cyc;
      logic [15:0] cnt;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        start;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_count;
   logic        err;

   sobel_frame_ctrl_if hs ();

   sobel_frame_ctrl #(
      .WIDTH     (W),
      .HEIGHT    (H),
      .IN_QUOTA  (Q),
      .OUT_QUOTA (Q)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .hs          (hs),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .err         (err)
   );

   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;
   int          tokens = 0;
   int          reads = 0;
   logic        auto_rd;
   logic        force_rd;
   exp_t        exp_q[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Let combinational handshakes settle, then play the sobel stage.
   task automatic settle();
      #1;
      hs.sobel_rd_en = force_rd | (auto_rd & reset & ~hs.sobel_empty);
      hs.sobel_wr_en = reset & (tokens > 0) & ~hs.sobel_full;
      #1;
   endtask

   // Book-keep what happens at the coming edge, then move to the next cycle.
   task automatic advance();
      if (hs.src_rd_en === 1'b1) begin
         tokens++;
         reads++;
      end
      if (hs.sobel_wr_en === 1'b1) tokens--;
      if (!reset) tokens = 0;
      @(negedge clock);
   endtask

   // Offsets are relative to the cycle carrying the start pulse (offset 0).
   task automatic run_frame(input int ncyc, input int full_from, input int full_to,
                            input int restart_at, input int rst_at);
      for (int k = 0; k < ncyc; k++) begin
         start       = (k == 0) || (k == restart_at);
         hs.dst_full = (k >= full_from) && (k <= full_to);
         reset       = (k != rst_at);
         settle();
         if (hs.dst_full) check("sobel_full_while_dst_full", hs.sobel_full, 1);
         if (k == 13 && rst_at < 0) begin
            check("drain_sobel_empty", hs.sobel_empty, 1);
            check("drain_src_rd_en", hs.src_rd_en, 0);
         end
         if (restart_at >= 0 && k == restart_at + 2) check("done_to_run_busy", busy, 1);
         if (rst_at >= 0 && k == rst_at + 1) begin
            check("rst_busy", busy, 0);
            check("rst_sobel_empty", hs.sobel_empty, 1);
            check("rst_in_cnt", 32'(dut.u_in_cnt.count), 0);
            check("rst_out_cnt", 32'(dut.u_out_cnt.count), 0);
            check("rst_err", err, 0);
            check("rst_frame_count", frame_count, 0);
         end
         advance();
      end
      start       = 1'b0;
      hs.dst_full = 1'b0;
      reset       = 1'b1;
   endtask

   // Monitor: every frame_done must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clock);
         #3;
         if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("frame_done_unexpected", frame_done, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("done_cycle", cyc, e.cyc);
               check("done_count_before", frame_count, 32'(e.cnt));
            end
         end
      end
   end

   initial begin
      reset          = 1'b0;
      start          = 1'b0;
      auto_rd        = 1'b1;
      force_rd       = 1'b0;
      hs.src_empty   = 1'b0;
      hs.dst_full    = 1'b0;
      hs.sobel_rd_en = 1'b0;
      hs.sobel_wr_en = 1'b0;
      @(negedge clock);

      // Reset held with a full upstream FIFO: nothing may leak through.
      repeat (3) begin
         settle();
         check("reset_sobel_empty", hs.sobel_empty, 1);
         check("reset_src_rd_en", hs.src_rd_en, 0);
         check("reset_busy", busy, 0);
         advance();
      end
      reset = 1'b1;
      settle();
      check("idle_sobel_full", hs.sobel_full, 1);
      check("idle_frame_count", frame_count, 0);
      check("idle_err", err, 0);
      check("idle_busy", busy, 0);
      advance();

      // Plain frame: 12 reads, last write lands at offset 13, DONE at 14.
      reads = 0;
      exp_q.push_back('{cyc + 14, 16'd0});
      run_frame(16, -1, -1, -1, -1);
      check("f1_reads", reads, Q);
      check("f1_frame_count", frame_count, 1);
      check("f1_busy", busy, 0);

      // Downstream full for 5 cycles: completion slips by exactly 5.
      reads = 0;
      exp_q.push_back('{cyc + 19, 16'd1});
      run_frame(21, 5, 9, -1, -1);
      check("f2_reads", reads, Q);
      check("f2_frame_count", frame_count, 2);

      // Start during DRAIN: DONE goes straight to RUN for a second frame.
      reads = 0;
      exp_q.push_back('{cyc + 14, 16'd2});
      exp_q.push_back('{cyc + 28, 16'd3});
      run_frame(30, -1, -1, 13, -1);
      check("f34_reads", reads, 2 * Q);
      check("f34_frame_count", frame_count, 4);
      check("f34_err", err, 0);

      // Read while presented empty: sticky error, nothing forwarded.
      force_rd = 1'b1;
      settle();
      check("force_src_rd_en", hs.src_rd_en, 0);
      advance();
      force_rd = 1'b0;
      repeat (3) begin
         settle();
         advance();
      end
      check("err_sticky", err, 1);

      // Reset after read 6 drops the frame; checks live inside run_frame.
      reads = 0;
      run_frame(10, -1, -1, -1, 7);
      check("rst_reads", reads, 6);

      // A fresh frame after that reset is a full 12 reads.
      reads = 0;
      exp_q.push_back('{cyc + 14, 16'd0});
      run_frame(16, -1, -1, -1, -1);
      check("f5_reads", reads, Q);
      check("f5_frame_count", frame_count, 1);
      check("f5_err", err, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer wrapped around the `sobel` streaming stage. It sits between the upstream pixel FIFO and the downstream FIFO and gates the sobel handshakes so the stage sees exactly one frame's pixel quota, never pulls pixels of the next frame early, and finishes the frame before the next one is admitted. It exposes start/busy/done status and a frame counter for the HPS/control logic.

## Interface
- WIDTH, 568, frame width in pixels
- HEIGHT, 320, frame height in pixels
- IN_QUOTA, WIDTH*HEIGHT, pixels admitted from upstream per frame
- OUT_QUOTA, WIDTH*HEIGHT, sobel writes that complete a frame
- clock  in  1  single clock domain
- reset  in  1  synchronous, active-low
- start  in  1  request one frame (pulse or level)
- src_empty  in  1  upstream FIFO empty
- src_rd_en  out  1  upstream FIFO read strobe
- sobel_rd_en  in  1  sobel `in_rd_en`
- sobel_empty  out  1  drives sobel `in_empty`
- dst_full  in  1  downstream FIFO full
- sobel_wr_en  in  1  sobel `out_wr_en`; data goes straight to the downstream FIFO
- sobel_full  out  1  drives sobel `out_full`
- busy  out  1  frame in progress (RUN, DRAIN or DONE)
- frame_done  out  1  one-cycle pulse per completed frame
- frame_count  out  16  completed frames, wraps 0xFFFF->0
- err  out  1  sticky protocol error

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset puts the block in IDLE with in_cnt=0, out_cnt=0, pending=0, frame_count=0, frame_done=0, err=0.
- gate_in = (state==RUN) && in_cnt<IN_QUOTA.
- gate_out = state in {RUN, DRAIN}.
- sobel_empty = src_empty | ~gate_in.
- src_rd_en = sobel_rd_en & gate_in.
- sobel_full = dst_full | ~gate_out.
- in_cnt increments on src_rd_en. out_cnt increments on sobel_wr_en & gate_out & ~dst_full. Both counters are $clog2(quota+1) bits and saturate at their quota.
- IDLE -> RUN when start or pending. Entering RUN clears in_cnt, out_cnt and pending.
- RUN -> DRAIN when in_cnt==IN_QUOTA.
- DRAIN -> DONE when out_cnt==OUT_QUOTA. A write that reaches OUT_QUOTA during RUN is held and the transition is taken on the first DRAIN cycle.
- DONE lasts 1 cycle: frame_done=1, frame_count++. Goes to RUN if start or pending, else IDLE.
- start in RUN or DRAIN sets pending; multiple starts collapse into one. start in DONE goes directly to RUN.
- err is set on sobel_rd_en & ~gate_in (read while presented empty), or on sobel_wr_en & sobel_full (write while presented full). err is cleared only by reset.
- Reset mid-frame returns to IDLE and drops the frame. Resetting the sobel stage is the parent's job.

## Timing
- sobel_empty, sobel_full and src_rd_en are combinational from state, counters and inputs; there are no registered paths on the handshakes.
- The gate closes in the same cycle the last quota read is accepted: the read at in_cnt==IN_QUOTA-1 passes, and the following cycle shows sobel_empty=1.
- RUN->DRAIN: 1 cycle after the last read. DRAIN->DONE: 1 cycle after the OUT_QUOTA-th write. frame_done is asserted in that DONE cycle.
- Back-to-back frames: DONE->RUN is 1 cycle, so the gap from the last write to the first read of the next frame is at least 2 cycles.
- While the block is in IDLE, including immediately after reset: sobel_empty=1, sobel_full=1, src_rd_en=0, busy=0.

## Structure
- `sobel_ctrl_pkg` holds the state enum and a `quota_w(n)` width function.
- Two instances of sub-module `quota_counter` (clear, increment, saturate at QUOTA, `at_quota` flag) implement in_cnt and out_cnt.
- The rest is a single always_ff/always_comb FSM.

## Test plan
Parameters: WIDTH=4, HEIGHT=3, quotas=12.
- Reset low 3 cycles, upstream full, start=0 -> sobel_empty=1, src_rd_en=0, busy=0 throughout.
- start pulse, sobel reads every cycle -> exactly 12 src_rd_en, sobel_empty=1 from read 13 on; after 12 writes, frame_done pulses once and frame_count=1.
- dst_full held high for 5 cycles mid-frame -> sobel_full=1 for those cycles, out_cnt frozen, frame_done delayed by 5 cycles.
- start pulsed during DRAIN -> DONE goes straight to RUN, no IDLE cycle, frame_count=2 after the second frame.
- Force sobel_rd_en=1 while sobel_empty=1 -> err=1 and stays 1 until reset; src_rd_en stays 0.
- Reset asserted after read 6 -> next cycle IDLE, counters 0; a new start admits a full 12 reads.
